// File: rtl/ascon_share_serializer_if.sv
// Stream bundle for the share serializer: word input side and chunk output side.
// master = environment (producer/consumer), slave = the serializer.
interface ascon_share_serializer_if #(
  parameter int unsigned NUM_SHARES = 11,
  parameter int unsigned PAR        = 6,
  parameter int unsigned WORD_SIZE  = 64
) ();
  localparam int unsigned NbW = $clog2(WORD_SIZE + 1);

  logic                             in_valid;
  logic                             in_ready;
  logic                             in_mode;
  logic [NUM_SHARES*WORD_SIZE-1:0]  in_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [NUM_SHARES*PAR-1:0]        out_data;
  logic [NbW-1:0]                   out_nbits;
  logic                             out_last;
  logic                             out_mode;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_nbits, out_last, out_mode
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_nbits, out_last, out_mode
  );
endinterface

// File: rtl/ascon_share_serializer.sv
// Serializes one 64-bit Ascon word (masked: all shares lane-parallel, unmasked: share 0 only)
// LSB-first into fixed-width chunks over a valid/ready stream.
module ascon_share_serializer #(
  parameter int unsigned NUM_SHARES = 11,
  parameter int unsigned PAR        = 6,
  parameter int unsigned WORD_SIZE  = 64
) (
  input logic                     clk,
  input logic                     rst,
  ascon_share_serializer_if.slave bus
);
  localparam int unsigned Wu     = (NUM_SHARES * PAR < WORD_SIZE) ? NUM_SHARES * PAR : WORD_SIZE;
  localparam int unsigned NumM   = (WORD_SIZE + PAR - 1) / PAR;
  localparam int unsigned NumU   = (WORD_SIZE + Wu - 1) / Wu;
  localparam int unsigned NumMax = (NumM > NumU) ? NumM : NumU;
  localparam int unsigned CntW   = $clog2(NumMax + 1);
  localparam int unsigned NbW    = $clog2(WORD_SIZE + 1);
  localparam int unsigned ShW    = NUM_SHARES * WORD_SIZE;
  localparam int unsigned OutW   = NUM_SHARES * PAR;

  localparam logic [CntW-1:0] CntLastM = CntW'(NumM - 1);
  localparam logic [CntW-1:0] CntLastU = CntW'(NumU - 1);
  localparam logic [NbW-1:0]  NbM      = NbW'(PAR);
  localparam logic [NbW-1:0]  NbLastM  = NbW'(WORD_SIZE - (NumM - 1) * PAR);
  localparam logic [NbW-1:0]  NbU      = NbW'(Wu);
  localparam logic [NbW-1:0]  NbLastU  = NbW'(WORD_SIZE - (NumU - 1) * Wu);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e          state_q, state_d;
  logic [ShW-1:0]  sreg_q, sreg_d;
  logic            mode_q, mode_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            valid_c, last_c, ready_c, load, fire;
  logic [OutW-1:0] data_c;
  logic [NbW-1:0]  nbits_c;

  always_comb begin
    valid_c = (state_q == StShift);
    last_c  = valid_c && (cnt_q == (mode_q ? CntLastU : CntLastM));
    nbits_c = '0;
    data_c  = '0;
    if (valid_c) begin
      if (mode_q) begin
        nbits_c       = last_c ? NbLastU : NbU;
        data_c[Wu-1:0] = sreg_q[Wu-1:0];
      end else begin
        nbits_c = last_c ? NbLastM : NbM;
        // Each lane only ever sees the low bits of its own share.
        for (int i = 0; i < NUM_SHARES; i++) begin
          data_c[i*PAR +: PAR] = sreg_q[i*WORD_SIZE +: PAR];
        end
      end
    end
    // Ready is a function of state and out_ready only, never of in_valid.
    ready_c = !rst && ((state_q == StIdle) || (valid_c && last_c && bus.out_ready));
    load    = bus.in_valid && ready_c;
    fire    = valid_c && bus.out_ready;
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = valid_c;
  assign bus.out_data  = data_c;
  assign bus.out_nbits = nbits_c;
  assign bus.out_last  = last_c;
  assign bus.out_mode  = valid_c && mode_q;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = StShift;
      mode_d  = bus.in_mode;
      cnt_d   = '0;
      sreg_d  = bus.in_mode ? ShW'(bus.in_data[WORD_SIZE-1:0]) : bus.in_data;
    end else if (fire) begin
      cnt_d = cnt_q + CntW'(1);
      if (last_c) begin
        state_d = StIdle;
      end
      if (mode_q) begin
        sreg_d[WORD_SIZE-1:0] = sreg_q[WORD_SIZE-1:0] >> Wu;
      end else begin
        for (int i = 0; i < NUM_SHARES; i++) begin
          sreg_d[i*WORD_SIZE +: WORD_SIZE] = sreg_q[i*WORD_SIZE +: WORD_SIZE] >> PAR;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
